// File: rtl/inst_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package inst_cache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_DONE   = 2'd2
  } ic_state_e;

  localparam int unsigned IC_LINE_WORDS = 4;
  localparam int unsigned IC_NUM_LINES  = 16;

endpackage

// File: rtl/inst_cache_array.sv
// Tag/valid/data storage: one write port, one asynchronous read port, flush-all.
module inst_cache_array #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_all,
  input  logic                          we,
  input  logic                          tag_we,
  input  logic [$clog2(NUM_LINES)-1:0]  w_index,
  input  logic [$clog2(LINE_WORDS)-1:0] w_word,
  input  logic [31:0]                   w_data,
  input  logic [TAG_W-1:0]              w_tag,
  input  logic [$clog2(NUM_LINES)-1:0]  r_index,
  input  logic [$clog2(LINE_WORDS)-1:0] r_word,
  output logic                          r_valid,
  output logic [TAG_W-1:0]              r_tag,
  output logic [31:0]                   r_data
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];

  // Flush takes priority so a line finishing on the flush cycle stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[w_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[{w_index, w_word}] <= w_data;
    end
    if (tag_we) begin
      tag_mem[w_index] <= w_tag;
    end
  end

  assign r_valid = valid[r_index];
  assign r_tag   = tag_mem[r_index];
  assign r_data  = data_mem[{r_index, r_word}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, word-by-word line refill.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = IC_LINE_WORDS,
  parameter int unsigned NUM_LINES  = IC_NUM_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        flush,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_stall,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int unsigned OB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TW = 30 - OB - IB;

  ic_state_e     state;
  logic [TW-1:0] base_tag;
  logic [IB-1:0] base_index;
  logic [OB-1:0] cnt;
  logic          discard;

  logic [OB-1:0] a_word;
  logic [IB-1:0] a_index;
  logic [TW-1:0] a_tag;
  logic          r_valid;
  logic [TW-1:0] r_tag;
  logic [31:0]   r_data;
  logic          hit;
  logic          word_we;
  logic          last_word;
  logic          unused_ok;

  assign a_word  = inst_addr[OB+1:2];
  assign a_index = inst_addr[OB+IB+1:OB+2];
  assign a_tag   = inst_addr[31:OB+IB+2];

  assign unused_ok = &{1'b0, mem_stall, inst_addr[1:0]};

  assign hit        = inst_ren & r_valid & (r_tag == a_tag) & (state == IC_IDLE);
  assign inst_data  = hit ? r_data : '0;
  assign inst_stall = rst_n & inst_ren & ~hit;

  // An ack counts only against an outstanding request; gap-cycle acks are stray.
  assign word_we   = (state == IC_REFILL) & mem_ren & mem_ack;
  assign last_word = (cnt == OB'(LINE_WORDS - 1));

  inst_cache_array #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (TW)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_all (flush),
    .we        (word_we),
    .tag_we    (word_we & last_word & ~discard & ~flush),
    .w_index   (base_index),
    .w_word    (cnt),
    .w_data    (mem_data),
    .w_tag     (base_tag),
    .r_index   (a_index),
    .r_word    (a_word),
    .r_valid   (r_valid),
    .r_tag     (r_tag),
    .r_data    (r_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IC_IDLE;
      base_tag   <= '0;
      base_index <= '0;
      cnt        <= '0;
      discard    <= 1'b0;
      mem_ren    <= 1'b0;
      mem_addr   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (hit && hit_cnt != '1) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      case (state)
        IC_IDLE: begin
          discard <= 1'b0;
          if (inst_ren && !hit) begin
            state      <= IC_REFILL;
            base_tag   <= a_tag;
            base_index <= a_index;
            cnt        <= '0;
            mem_ren    <= 1'b1;
            mem_addr   <= {2'b00, a_tag, a_index, {OB{1'b0}}};
            if (miss_cnt != '1) begin
              miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end
        IC_REFILL: begin
          if (flush) begin
            discard <= 1'b1;
          end
          // Drop ren for one cycle after each ack so every word gets a fresh request edge.
          if (word_we) begin
            mem_ren <= 1'b0;
            cnt     <= cnt + OB'(1);
            if (last_word) begin
              state <= IC_DONE;
            end
          end else if (!mem_ren) begin
            mem_ren  <= 1'b1;
            mem_addr <= {2'b00, base_tag, base_index, cnt};
          end
        end
        IC_DONE: begin
          discard <= 1'b0;
          state   <= IC_IDLE;
        end
        default: begin
          state   <= IC_IDLE;
          mem_ren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache with an inst_rom model (ack 8 cycles after ren).
module tb_inst_cache;

  localparam int unsigned LW = 4;
  localparam int unsigned NL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_ren = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        flush = 1'b0;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_stall;
  logic        mem_ack;
  logic        model_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  assign mem_ack = model_ack | stray_ack;

  inst_cache #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_stall (inst_stall),
    .flush      (flush),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_stall  (mem_stall),
    .mem_ack    (mem_ack),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  // inst_rom model: accept a request when idle, ack 8 cycles later with data = word_addr*4
  int          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_req;
  int          ack_cnt = 0;
  logic [31:0] req_q[$];

  assign mem_stall = (mem_busy != 0);

  always @(negedge clk) begin
    model_ack = 1'b0;
    if (!rst_n) begin
      mem_busy = 0;
    end else if (mem_busy != 0) begin
      mem_wait--;
      if (mem_wait == 0) begin
        model_ack = 1'b1;
        mem_data  = mem_req * 4;
        mem_busy  = 0;
        ack_cnt++;
      end
    end else if (mem_ren) begin
      mem_busy = 1;
      mem_wait = 8;
      mem_req  = mem_addr;
      req_q.push_back(mem_addr);
    end
  end

  // Reference model: which line address each index holds, plus expected counters
  bit          m_valid [NL];
  logic [31:0] m_line  [NL];
  int          m_hit = 0;
  int          m_miss = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a / (LW * 4);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(line_of(a) % NL);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && m_line[idx_of(a)] == line_of(a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    m_valid[idx_of(a)] = 1'b1;
    m_line[idx_of(a)]  = line_of(a);
  endtask

  task automatic check_counters(input string nm);
    chk({nm, " hit_cnt"},  {16'h0, hit_cnt},  (m_hit  > 65535) ? 32'hFFFF : m_hit);
    chk({nm, " miss_cnt"}, {16'h0, miss_cnt}, (m_miss > 65535) ? 32'hFFFF : m_miss);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; inst_ren = 1'b0; flush = 1'b0;
    model_clear(); m_hit = 0; m_miss = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_acks(input int target, input string nm);
    int n = 0;
    while (ack_cnt < target && n < 400) begin @(negedge clk); #1; n++; end
    chk({nm, " ack wait"}, {31'b0, ack_cnt >= target}, 32'h1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete fetch: hold inst_ren until the stall clears, take the hit cycle, release.
  task automatic fetch(input logic [31:0] a, input bit exp_hit, input string nm);
    int n = 0;
    @(negedge clk);
    inst_ren = 1'b1; inst_addr = a; #1;
    chk({nm, " hit"}, {31'b0, !inst_stall}, {31'b0, exp_hit});
    while (inst_stall && n < 400) begin @(negedge clk); #1; n++; end
    chk({nm, " stall clears"}, {31'b0, !inst_stall}, 32'h1);
    chk({nm, " data"}, inst_data, a & ~32'h3);
    @(negedge clk);
    inst_ren = 1'b0; #1;
    if (!exp_hit) m_miss++;
    m_hit++;
    model_fill(a);
    check_counters(nm);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int qbase;
    int abase;
    logic [31:0] a;
    string nm;

    vecs[0] = '{32'h000, 1'b0, 32'h000};
    vecs[1] = '{32'h004, 1'b1, 32'h004};
    vecs[2] = '{32'h008, 1'b1, 32'h008};
    vecs[3] = '{32'h00C, 1'b1, 32'h00C};
    vecs[4] = '{32'h100, 1'b0, 32'h100};
    vecs[5] = '{32'h000, 1'b0, 32'h000};
    vecs[6] = '{32'h013, 1'b0, 32'h010};
    vecs[7] = '{32'h01E, 1'b1, 32'h01C};

    do_reset();
    #1;
    chk("reset hit_cnt",   {16'h0, hit_cnt},  32'h0);
    chk("reset miss_cnt",  {16'h0, miss_cnt}, 32'h0);
    chk("reset mem_ren",   {31'b0, mem_ren},  32'h0);
    chk("reset mem_addr",  mem_addr,          32'h0);
    chk("reset stall",     {31'b0, inst_stall}, 32'h0);
    chk("reset inst_data", inst_data,         32'h0);

    req_q.delete();
    for (int i = 0; i < 8; i++) begin
      $sformat(nm, "vec%0d", i);
      fetch(vecs[i].addr, vecs[i].exp_hit, nm);
      chk({nm, " table data"}, vecs[i].addr & ~32'h3, vecs[i].exp_data);
      if (i == 0) begin
        chk("cold refill count", req_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) chk("cold mem_addr seq", req_q[k], k);
      end
      if (i == 3) chk("hits issue no mem_ren", req_q.size(), 32'd4);
    end

    // flush in IDLE concurrent with a hit: data still returned, line invalid afterward
    @(negedge clk);
    inst_ren = 1'b1; inst_addr = 32'h01C; flush = 1'b1; #1;
    chk("flush+hit stall", {31'b0, inst_stall}, 32'h0);
    chk("flush+hit data", inst_data, 32'h01C);
    @(negedge clk);
    inst_ren = 1'b0; flush = 1'b0;
    m_hit++; model_clear();
    qbase = req_q.size();
    fetch(32'h01C, 1'b0, "after idle flush");
    chk("after idle flush refill", req_q.size(), qbase + 4);

    // flush while refilling: the line must not be validated
    abase = ack_cnt;
    @(negedge clk);
    inst_ren = 1'b1; inst_addr = 32'h200;
    wait_acks(abase + 1, "flush refill");
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; inst_ren = 1'b0;
    wait_acks(abase + 4, "flush refill end");
    idle_cycles(4);
    m_miss++; model_clear();
    fetch(32'h200, 1'b0, "refetch after refill flush");

    // inst_ren dropped mid-refill: line is still completed and validated
    abase = ack_cnt;
    @(negedge clk);
    inst_ren = 1'b1; inst_addr = 32'h300;
    wait_acks(abase + 1, "ren drop");
    @(negedge clk); inst_ren = 1'b0;
    wait_acks(abase + 4, "ren drop end");
    idle_cycles(4);
    m_miss++; model_fill(32'h300);
    fetch(32'h308, 1'b1, "hit after ren drop");

    // idle with stray acks
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      stray_ack = (c % 5 == 2);
      #1;
      chk("idle stall", {31'b0, inst_stall}, 32'h0);
      chk("idle mem_ren", {31'b0, mem_ren}, 32'h0);
    end
    stray_ack = 1'b0;
    check_counters("idle");
    fetch(32'h304, 1'b1, "hit after stray acks");

    // random traffic against the reference model, occasional IDLE flushes
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        model_clear();
      end
      a = {22'b0, 10'($urandom_range(0, 1023))};
      $sformat(nm, "rand%0d@%h", r, a);
      fetch(a, model_hit(a), nm);
    end

    // reset asserted after the 2nd ack of a refill
    do_reset();
    abase = ack_cnt;
    @(negedge clk);
    inst_ren = 1'b1; inst_addr = 32'h040;
    wait_acks(abase + 2, "reset mid refill");
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mid-reset mem_ren", {31'b0, mem_ren}, 32'h0);
    chk("mid-reset stall", {31'b0, inst_stall}, 32'h0);
    chk("mid-reset hit_cnt", {16'h0, hit_cnt}, 32'h0);
    chk("mid-reset miss_cnt", {16'h0, miss_cnt}, 32'h0);
    inst_ren = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    model_clear(); m_hit = 0; m_miss = 0;
    fetch(32'h040, 1'b0, "refetch after reset");
    fetch(32'h000, 1'b0, "cold 0 after reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
